// File: rtl/lift_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lift_motion_ctrl
//  Description : Per-car motion sequencer. Takes the scheduler's direction
//                and the door status, then steps the car one floor at a
//                time. Each step has a timed travel phase and a timed dwell
//                phase. Errors latch a fault flag until it is cleared.
//  Ports       : clk, reset (async, active-high), enable (freeze when 0),
//                doorState, faultClr, currentFloor[FLOOR_W],
//                currentDirection[2] (00 STOP, 10 UP, 01 DOWN, 11 illegal)
//                -> nextFloor[FLOOR_W], move, arrive (1-cycle strobe),
//                fault (latched), busy (MOVE or HOLD)
//  Revision    : 1.0  initial release
// ============================================================================
module lift_motion_ctrl #(
   parameter int NUM_FLOORS   = 7,
   parameter int FLOOR_W      = 3,
   parameter int CNT_W        = 32,
   parameter int CLK_PER_MOVE = 1000000,
   parameter int CLK_PER_HOLD = 10000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               doorState,
   input  logic               faultClr,
   input  logic [FLOOR_W-1:0] currentFloor,
   input  logic [1:0]         currentDirection,
   output logic [FLOOR_W-1:0] nextFloor,
   output logic               move,
   output logic               arrive,
   output logic               fault,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MOVE  = 2'd1,
      HOLD  = 2'd2,
      FAULT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0]   MOVE_LOAD = CNT_W'(CLK_PER_MOVE - 1);
   localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(CLK_PER_HOLD - 1);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS);
   localparam logic [FLOOR_W-1:0] ONE_FLOOR = FLOOR_W'(1);
   localparam logic [1:0]         DIR_STOP  = 2'b00;
   localparam logic [1:0]         DIR_UP    = 2'b10;
   localparam logic [1:0]         DIR_DOWN  = 2'b01;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   timer, timer_nxt;
   logic [FLOOR_W-1:0] floor_nxt;
   logic               move_nxt, arrive_nxt, fault_nxt, busy_nxt;
   logic               go_fault;

   // State register and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         timer     <= '0;
         nextFloor <= ONE_FLOOR;
         move      <= 1'b0;
         arrive    <= 1'b0;
         fault     <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         timer     <= timer_nxt;
         nextFloor <= floor_nxt;
         move      <= move_nxt;
         arrive    <= arrive_nxt;
         fault     <= fault_nxt;
         busy      <= busy_nxt;
      end
   end

   // Next-state and output logic. With enable low, every default holds
   // the current value except arrive, which is a strobe and drops to 0.
   always_comb begin
      state_nxt  = state;
      timer_nxt  = timer;
      floor_nxt  = nextFloor;
      move_nxt   = move;
      fault_nxt  = fault;
      arrive_nxt = 1'b0;
      go_fault   = 1'b0;

      if (enable) begin
         unique case (state)
            IDLE: begin
               // The range check comes first, so the +/-1 below can never wrap.
               if (currentFloor == '0 || currentFloor > TOP_FLOOR) begin
                  go_fault = 1'b1;
               end else if (doorState) begin
                  state_nxt = HOLD;
                  timer_nxt = HOLD_LOAD;
                  floor_nxt = currentFloor;
               end else begin
                  unique case (currentDirection)
                     DIR_STOP: floor_nxt = currentFloor;
                     DIR_UP: begin
                        if (currentFloor < TOP_FLOOR) begin
                           state_nxt = MOVE;
                           timer_nxt = MOVE_LOAD;
                           floor_nxt = currentFloor + ONE_FLOOR;
                           move_nxt  = 1'b1;
                        end else begin
                           go_fault = 1'b1;
                        end
                     end
                     DIR_DOWN: begin
                        if (currentFloor > ONE_FLOOR) begin
                           state_nxt = MOVE;
                           timer_nxt = MOVE_LOAD;
                           floor_nxt = currentFloor - ONE_FLOOR;
                           move_nxt  = 1'b1;
                        end else begin
                           go_fault = 1'b1;
                        end
                     end
                     default: go_fault = 1'b1;
                  endcase
               end
               if (go_fault) begin
                  state_nxt = FAULT;
                  fault_nxt = 1'b1;
                  move_nxt  = 1'b0;
               end
            end
            // The travel step always runs to completion. Door and direction
            // changes seen during travel are ignored.
            MOVE: begin
               if (timer != '0) begin
                  timer_nxt = timer - CNT_W'(1);
               end else begin
                  state_nxt  = HOLD;
                  timer_nxt  = HOLD_LOAD;
                  move_nxt   = 1'b0;
                  arrive_nxt = 1'b1;
               end
            end
            // The dwell restarts for as long as the door stays active.
            HOLD: begin
               if (doorState) begin
                  timer_nxt = HOLD_LOAD;
               end else if (timer != '0) begin
                  timer_nxt = timer - CNT_W'(1);
               end else begin
                  state_nxt = IDLE;
               end
            end
            FAULT: begin
               move_nxt  = 1'b0;
               fault_nxt = 1'b1;
               if (faultClr) begin
                  state_nxt = IDLE;
                  fault_nxt = 1'b0;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end

      busy_nxt = (state_nxt == MOVE) || (state_nxt == HOLD);
   end

endmodule
`default_nettype wire
